// File: rtl/execution_controller.sv
// Execution controller: decides each clock whether the CPU advances, across
// fast run, prescaled slow run, single step and run-to-breakpoint modes.
module execution_controller #(
  parameter int PRESCALE_DIV = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_s2_n,
  input  logic [1:0]  mode,
  input  logic        step_req,
  input  logic [7:0]  breakpoint,
  input  logic        instr_done,
  input  logic [7:0]  pc_next,
  output logic        cycle_enable,
  output logic        halted,
  output logic        bp_hit,
  output logic [15:0] instr_count,
  output logic [2:0]  state_out
);

  localparam int CNT_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);

  localparam logic [2:0] ST_HALTED = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_RUN_BP = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  localparam logic [1:0] MODE_FAST  = 2'b00;
  localparam logic [1:0] MODE_SLOW  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BREAK = 2'b11;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] presc_cnt;
  logic             tick;
  logic             abort_pend;
  logic             retire;
  logic             bp_match;
  logic             slow_run;

  assign tick     = (presc_cnt == CNT_LAST);
  assign slow_run = (state == ST_RUN) && (mode == MODE_SLOW);
  assign retire   = instr_done & cycle_enable;
  assign bp_match = (pc_next == breakpoint);

  // In RUN a pending switch to STEP/BREAK still enables: the in-flight
  // instruction keeps moving while the mode change is taken into DRAIN.
  always_comb begin
    cycle_enable = 1'b0;
    case (state)
      ST_RUN:    cycle_enable = (mode == MODE_SLOW) ? tick : 1'b1;
      ST_STEP,
      ST_RUN_BP,
      ST_DRAIN:  cycle_enable = 1'b1;
      default:   cycle_enable = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HALTED: begin
        if (mode == MODE_FAST || mode == MODE_SLOW)
          state_nxt = ST_RUN;
        else if (mode == MODE_STEP && step_req)
          state_nxt = ST_STEP;
        else if (mode == MODE_BREAK && step_req)
          state_nxt = ST_RUN_BP;
      end
      ST_RUN: begin
        if (mode == MODE_STEP || mode == MODE_BREAK)
          state_nxt = ST_DRAIN;
      end
      ST_STEP,
      ST_DRAIN: begin
        if (retire)
          state_nxt = ST_HALTED;
      end
      ST_RUN_BP: begin
        if (retire && (bp_match || abort_pend))
          state_nxt = ST_HALTED;
        else if (mode == MODE_FAST || mode == MODE_SLOW)
          state_nxt = ST_RUN;
        else if (mode == MODE_STEP)
          state_nxt = ST_DRAIN;
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_s2_n) begin
      state       <= ST_HALTED;
      presc_cnt   <= '0;
      abort_pend  <= 1'b0;
      bp_hit      <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      state <= state_nxt;

      if (slow_run)
        presc_cnt <= tick ? '0 : presc_cnt + CNT_W'(1);
      else
        presc_cnt <= '0;

      // Entering HALTED always drops the abort, even if requested this cycle.
      if (state_nxt == ST_HALTED)
        abort_pend <= 1'b0;
      else if (state == ST_RUN_BP && step_req)
        abort_pend <= 1'b1;

      if (state == ST_RUN_BP && retire && bp_match)
        bp_hit <= 1'b1;
      else if (state == ST_HALTED && state_nxt != ST_HALTED)
        bp_hit <= 1'b0;

      if (retire)
        instr_count <= instr_count + 16'd1;
    end
  end

  assign halted    = (state == ST_HALTED);
  assign state_out = state;

endmodule
